// File: rtl/execute_mc_pkg.sv
// -----------------------------------------------------------------------------
// execute_mc_pkg
// Shared Y86 encodings for the multi-cycle execute stage: instruction codes,
// ALU function codes (including ALUMUL), branch/cmov conditions, register and
// status codes, the execute FSM state type and the condition-code record.
// Helper functions:
//   cond_eval(ifun, cc) - branch/cmov condition from the CC register
//   is_exc(stat)        - status is one of SADR/SINS/SHLT
// -----------------------------------------------------------------------------
package execute_mc_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;
    localparam logic [3:0] ALUMUL = 4'h4;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_MUL  = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (ifun)
            C_YES:   return 1'b1;
            C_LE:    return lt | cc.zf;
            C_L:     return lt;
            C_E:     return cc.zf;
            C_NE:    return ~cc.zf;
            C_GE:    return ~lt;
            C_G:     return ~lt & ~cc.zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

endpackage

// File: rtl/execute_mc_if.sv
// -----------------------------------------------------------------------------
// execute_mc_if
// Bundle of the E-stage inputs, M/W feedback and execute outputs.
//   master : pipeline / hazard side (drives E_*, M_*, m_*, W_*, e_flush_i)
//   slave  : execute_mc (drives e_Cnd_o, e_valA_o, e_valE_o, e_dstE_o,
//            e_dstM_o, e_busy_o)
// -----------------------------------------------------------------------------
interface execute_mc_if #(
    parameter int XLEN = 64
);
    logic            e_flush_i;
    logic [3:0]      E_icode_i;
    logic [3:0]      E_ifun_i;
    logic [XLEN-1:0] E_valC_i;
    logic [XLEN-1:0] E_valA_i;
    logic [XLEN-1:0] E_valB_i;
    logic [3:0]      E_dstE_i;
    logic [3:0]      E_dstM_i;
    logic [3:0]      E_srcA_i;
    logic [3:0]      M_dstM_i;
    logic [XLEN-1:0] m_valM_i;
    logic [2:0]      m_stat_i;
    logic [2:0]      W_stat_i;

    logic            e_Cnd_o;
    logic [XLEN-1:0] e_valA_o;
    logic [XLEN-1:0] e_valE_o;
    logic [3:0]      e_dstE_o;
    logic [3:0]      e_dstM_o;
    logic            e_busy_o;

    modport master (
        output e_flush_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
               E_dstE_i, E_dstM_i, E_srcA_i, M_dstM_i, m_valM_i, m_stat_i, W_stat_i,
        input  e_Cnd_o, e_valA_o, e_valE_o, e_dstE_o, e_dstM_o, e_busy_o
    );

    modport slave (
        input  e_flush_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
               E_dstE_i, E_dstM_i, E_srcA_i, M_dstM_i, m_valM_i, m_stat_i, W_stat_i,
        output e_Cnd_o, e_valA_o, e_valE_o, e_dstE_o, e_dstM_o, e_busy_o
    );
endinterface

// File: rtl/execute_mc_mul_iter.sv
// -----------------------------------------------------------------------------
// execute_mc_mul_iter
// Iterative shift-and-add multiplier retiring MUL_STEP multiplier bits per
// cycle; XLEN/MUL_STEP steps give the low XLEN bits of a*b.
// Ports:
//   clk_i, rst_n_i  clock, async active-low reset
//   start_i         load operands, clear accumulator, arm the step counter
//   flush_i         abort: counter cleared, no further steps
//   a_i, b_i        multiplier / multiplicand
//   done_o          the step on the coming edge is the final one
//   product_o       accumulator (valid once the final step has retired)
// -----------------------------------------------------------------------------
module execute_mc_mul_iter #(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int N  = XLEN / MUL_STEP;
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] digit;

    // Low MUL_STEP bits of the multiplier, zero-extended; the partial product
    // is truncated to XLEN, which is all the stage ever needs.
    assign digit = {{(XLEN-MUL_STEP){1'b0}}, a_q[MUL_STEP-1:0]};

    always_comb begin
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = '0;
            cnt_d = CW'(N);
        end else if (cnt_q != '0) begin
            acc_d = acc_q + (b_q * digit);
            a_d   = a_q >> MUL_STEP;
            b_d   = b_q << MUL_STEP;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign done_o    = (cnt_q == CW'(1));
    assign product_o = acc_q;

endmodule

// File: rtl/execute_mc.sv
// -----------------------------------------------------------------------------
// execute_mc
// Multi-cycle Y86 execute stage: single-cycle ALU, condition codes, branch /
// cmov condition, store-data forwarding, plus an iterative OPQ multiply that
// holds the pipeline through e_busy_o.
// Ports:
//   clk_i    clock
//   rst_n_i  async active-low reset
//   bus      execute_mc_if.slave (E-stage operands, M/W feedback, results)
//
// state   | meaning
// EX_IDLE | single-cycle ops; a multiply in E raises busy and starts here
// EX_MUL  | one MUL_STEP-bit step per cycle, busy held high
// EX_DONE | product on e_valE_o, busy low, CC written at the closing edge
// -----------------------------------------------------------------------------
module execute_mc
    import execute_mc_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 4
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    execute_mc_if.slave    bus
);

    localparam logic [XLEN-1:0] PLUS_EIGHT  = XLEN'(8);
    localparam logic [XLEN-1:0] MINUS_EIGHT = {{(XLEN-4){1'b1}}, 4'h8};

    ex_state_e       state_q;
    cc_t             cc_q;
    cc_t             cc_new;
    logic            cc_we;

    logic            is_opq;
    logic            is_mul;
    logic            set_cc;
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    logic [3:0]      alu_fun;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_r;
    logic            alu_of;

    assign is_opq = (bus.E_icode_i == I_OPQ);
    assign is_mul = is_opq && (bus.E_ifun_i == ALUMUL);
    assign set_cc = is_opq && !is_exc(bus.m_stat_i) && !is_exc(bus.W_stat_i);

    // A multiply only starts from IDLE; a flush in the same cycle cancels it.
    assign mul_start = (state_q == EX_IDLE) && is_mul && !bus.e_flush_i;

    execute_mc_mul_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mul_iter (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (mul_start),
        .flush_i   (bus.e_flush_i),
        .a_i       (bus.E_valA_i),
        .b_i       (bus.E_valB_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        alu_a = '0;
        case (bus.E_icode_i)
            I_OPQ, I_RRMOVQ:                   alu_a = bus.E_valA_i;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX: alu_a = bus.E_valC_i;
            I_CALL, I_PUSHQ:                   alu_a = MINUS_EIGHT;
            I_RET, I_POPQ:                     alu_a = PLUS_EIGHT;
            default:                           alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (bus.E_icode_i)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = bus.E_valB_i;
            default:                                                   alu_b = '0;
        endcase
    end

    always_comb begin
        alu_fun = is_opq ? bus.E_ifun_i : ALUADD;
        alu_r   = '0;
        alu_of  = 1'b0;
        case (alu_fun)
            ALUADD: begin
                alu_r  = alu_b + alu_a;
                alu_of = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (alu_r[XLEN-1] != alu_a[XLEN-1]);
            end
            ALUSUB: begin
                alu_r  = alu_b - alu_a;
                alu_of = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (alu_r[XLEN-1] != alu_b[XLEN-1]);
            end
            ALUAND:  alu_r = alu_b & alu_a;
            ALUXOR:  alu_r = alu_b ^ alu_a;
            default: alu_r = '0;
        endcase
    end

    // A multiply writes the CC exactly once, at its DONE edge; ordinary ALU
    // ops write while the FSM is idle. A flush suppresses the write.
    always_comb begin
        cc_new = '{zf: (alu_r == '0), sf: alu_r[XLEN-1], of: alu_of};
        cc_we  = 1'b0;
        if (is_mul) begin
            cc_new = '{zf: (mul_product == '0), sf: mul_product[XLEN-1], of: 1'b0};
            cc_we  = set_cc && !bus.e_flush_i && (state_q == EX_DONE);
        end else begin
            cc_we  = set_cc && !bus.e_flush_i && (state_q == EX_IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EX_IDLE;
            cc_q    <= CC_RESET;
        end else begin
            if (cc_we) begin
                cc_q <= cc_new;
            end
            if (bus.e_flush_i) begin
                state_q <= EX_IDLE;
            end else begin
                case (state_q)
                    EX_IDLE: if (is_mul)   state_q <= EX_MUL;
                    EX_MUL:  if (mul_done) state_q <= EX_DONE;
                    EX_DONE:               state_q <= EX_IDLE;
                    default:               state_q <= EX_IDLE;
                endcase
            end
        end
    end

    // Busy is dropped while reset is held so the stall releases immediately,
    // even though the multiply instruction may still sit in E.
    assign bus.e_busy_o = rst_n_i &&
                          (((state_q == EX_IDLE) && is_mul) || (state_q == EX_MUL));

    assign bus.e_Cnd_o  = cond_eval(bus.E_ifun_i, cc_q);
    assign bus.e_valE_o = (state_q == EX_DONE) ? mul_product : alu_r;

    assign bus.e_valA_o = (((bus.E_icode_i == I_RMMOVQ) || (bus.E_icode_i == I_PUSHQ)) &&
                           (bus.E_srcA_i == bus.M_dstM_i)) ? bus.m_valM_i : bus.E_valA_i;

    assign bus.e_dstE_o = ((bus.E_icode_i == I_RRMOVQ) && !bus.e_Cnd_o) ? RNONE : bus.E_dstE_i;
    assign bus.e_dstM_o = bus.E_dstM_i;

endmodule

// File: tb/tb_execute_mc.sv
module tb_execute_mc;
    import execute_mc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    execute_mc_if #(.XLEN(64)) bus ();

    execute_mc #(
        .XLEN     (64),
        .MUL_STEP (4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        bus.e_flush_i = 1'b0;
        bus.E_icode_i = icode;
        bus.E_ifun_i  = ifun;
        bus.E_valA_i  = a;
        bus.E_valB_i  = b;
        bus.E_valC_i  = c;
        bus.E_dstE_i  = 4'h1;
        bus.E_dstM_i  = 4'h2;
        bus.E_srcA_i  = 4'h3;
        bus.M_dstM_i  = RNONE;
        bus.m_valM_i  = 64'd0;
        bus.m_stat_i  = SAOK;
        bus.W_stat_i  = SAOK;
    endtask

    // Presents a multiply, counts busy cycles, captures the DONE-cycle outputs,
    // then lets the DONE edge commit and puts a NOP in E.
    task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input logic [2:0] mstat,
                           output int nbusy, output logic [63:0] res, output logic cnd);
        drive(I_OPQ, ALUMUL, a, b, 64'd0);
        bus.m_stat_i = mstat;
        nbusy = 0;
        res   = '1;
        cnd   = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.e_busy_o) begin
                nbusy++;
                step();
            end else begin
                res = bus.e_valE_o;
                cnd = bus.e_Cnd_o;
                break;
            end
        end
        step();
        drive(I_NOP, 4'h0, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(I_NOP, 4'h0, 64'd0, 64'd0, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.e_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.e_busy_o); end
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'h40);
        #1;
        checks++; if (bus.e_Cnd_o !== 1'b1) begin errors++; $display("FAIL reset_cc_je: got %b expected 1", bus.e_Cnd_o); end
        checks++; if (bus.e_valE_o !== 64'h40) begin errors++; $display("FAIL reset_jxx_valE: got %h expected 40", bus.e_valE_o); end
        drive(I_JXX, C_NE, 64'd0, 64'd0, 64'd0);
        #1;
        checks++; if (bus.e_Cnd_o !== 1'b0) begin errors++; $display("FAIL reset_cc_jne: got %b expected 0", bus.e_Cnd_o); end
        step();
    endtask

    task automatic test_alu();
        drive(I_OPQ, ALUADD, 64'd1, 64'd1, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_valE_o !== 64'd2) begin errors++; $display("FAIL add_valE: got %h expected 2", bus.e_valE_o); end
        checks++; if (bus.e_busy_o !== 1'b0) begin errors++; $display("FAIL add_busy: got %b expected 0", bus.e_busy_o); end
        step();
        drive(I_JXX, C_LE, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_Cnd_o !== 1'b0) begin errors++; $display("FAIL add_cc_jle: got %b expected 0", bus.e_Cnd_o); end
        step();
        drive(I_OPQ, ALUSUB, 64'd5, 64'd5, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_valE_o !== 64'd0) begin errors++; $display("FAIL sub_valE: got %h expected 0", bus.e_valE_o); end
        step();
        drive(I_JXX, C_LE, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_Cnd_o !== 1'b1) begin errors++; $display("FAIL sub_cc_jle: got %b expected 1", bus.e_Cnd_o); end
        step();
        drive(I_OPQ, ALUADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_valE_o !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL addov_valE: got %h expected 8000000000000000", bus.e_valE_o); end
        step();
        drive(I_JXX, C_L, 64'd0, 64'd0, 64'd0);
        #1;
        checks++; if (bus.e_Cnd_o !== 1'b0) begin errors++; $display("FAIL addov_jl: got %b expected 0", bus.e_Cnd_o); end
        drive(I_JXX, C_GE, 64'd0, 64'd0, 64'd0);
        #1;
        checks++; if (bus.e_Cnd_o !== 1'b1) begin errors++; $display("FAIL addov_jge: got %b expected 1", bus.e_Cnd_o); end
        step();
        drive(I_OPQ, ALUSUB, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_valE_o !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL subov_valE: got %h expected 7fffffffffffffff", bus.e_valE_o); end
        step();
        drive(I_JXX, C_L, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_Cnd_o !== 1'b1) begin errors++; $display("FAIL subov_jl: got %b expected 1", bus.e_Cnd_o); end
        drive(I_OPQ, ALUAND, 64'h3C, 64'hF0, 64'd0);
        #1;
        checks++; if (bus.e_valE_o !== 64'h30) begin errors++; $display("FAIL and_valE: got %h expected 30", bus.e_valE_o); end
        drive(I_OPQ, ALUXOR, 64'h3C, 64'hF0, 64'd0);
        #1;
        checks++; if (bus.e_valE_o !== 64'hCC) begin errors++; $display("FAIL xor_valE: got %h expected cc", bus.e_valE_o); end
        step();
        drive(I_OPQ, ALUSUB, 64'd5, 64'd5, 64'd0);
        step();
    endtask

    task automatic test_mul_basic();
        int nb; logic [63:0] r; logic c;
        run_mul(64'd7, 64'd6, SAOK, nb, r, c);
        checks++; if (nb !== 17) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 17", nb); end
        checks++; if (r !== 64'd42) begin errors++; $display("FAIL mul_valE: got %h expected 2a", r); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL mul_cnd_before_done_edge: got %b expected 0", c); end
        drive(I_JXX, C_NE, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_Cnd_o !== 1'b1) begin errors++; $display("FAIL mul_cc_jne: got %b expected 1", bus.e_Cnd_o); end
        drive(I_JXX, C_L, 64'd0, 64'd0, 64'd0);
        #1;
        checks++; if (bus.e_Cnd_o !== 1'b0) begin errors++; $display("FAIL mul_cc_jl: got %b expected 0", bus.e_Cnd_o); end
        step();
    endtask

    task automatic test_mul_signed_zero();
        int nb; logic [63:0] r; logic c;
        run_mul(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, SAOK, nb, r, c);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mul_neg_valE: got %h expected fffffffffffffff1", r); end
        drive(I_JXX, C_L, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_Cnd_o !== 1'b1) begin errors++; $display("FAIL mul_neg_sf: got %b expected 1", bus.e_Cnd_o); end
        step();
        run_mul(64'h1_0000_0000, 64'h1_0000_0000, SAOK, nb, r, c);
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL mul_wrap_valE: got %h expected 0", r); end
        checks++; if (nb !== 17) begin errors++; $display("FAIL mul_wrap_busy: got %0d expected 17", nb); end
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_Cnd_o !== 1'b1) begin errors++; $display("FAIL mul_wrap_zf: got %b expected 1", bus.e_Cnd_o); end
        step();
    endtask

    task automatic test_flush();
        drive(I_OPQ, ALUMUL, 64'd7, 64'd6, 64'd0);
        for (int i = 0; i < 5; i++) step();
        bus.e_flush_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.e_busy_o !== 1'b1) begin errors++; $display("FAIL flush_cycle_busy: got %b expected 1", bus.e_busy_o); end
        step();
        drive(I_NOP, 4'h0, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.e_busy_o); end
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0);
        #1;
        checks++; if (bus.e_Cnd_o !== 1'b1) begin errors++; $display("FAIL flush_cc_kept: got %b expected 1", bus.e_Cnd_o); end
        step();
        drive(I_OPQ, ALUADD, 64'd1, 64'd1, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_valE_o !== 64'd2) begin errors++; $display("FAIL flush_add_valE: got %h expected 2", bus.e_valE_o); end
        checks++; if (bus.e_busy_o !== 1'b0) begin errors++; $display("FAIL flush_add_busy: got %b expected 0", bus.e_busy_o); end
        step();
    endtask

    task automatic test_reset_mid();
        int nb; logic [63:0] r; logic c;
        drive(I_OPQ, ALUMUL, 64'd7, 64'd6, 64'd0);
        for (int i = 0; i < 3; i++) step();
        #2;
        checks++; if (bus.e_Cnd_o !== 1'b1 || bus.e_busy_o !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got cnd=%b busy=%b expected 1 1", bus.e_Cnd_o, bus.e_busy_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.e_busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.e_busy_o); end
        checks++; if (bus.e_Cnd_o !== 1'b0) begin errors++; $display("FAIL rst_mid_cc: got %b expected 0", bus.e_Cnd_o); end
        drive(I_NOP, 4'h0, 64'd0, 64'd0, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        run_mul(64'd3, 64'd4, SAOK, nb, r, c);
        checks++; if (r !== 64'd12 || nb !== 17) begin errors++; $display("FAIL rst_then_mul: got %h busy=%0d expected c busy=17", r, nb); end
    endtask

    task automatic test_forward_cmov();
        drive(I_RMMOVQ, 4'h0, 64'h55, 64'h1000, 64'h20);
        bus.M_dstM_i = 4'h3;
        bus.m_valM_i = 64'hAB;
        #1;
        checks++; if (bus.e_valA_o !== 64'hAB) begin errors++; $display("FAIL fwd_rmmovq: got %h expected ab", bus.e_valA_o); end
        checks++; if (bus.e_valE_o !== 64'h1020) begin errors++; $display("FAIL rmmovq_valE: got %h expected 1020", bus.e_valE_o); end
        checks++; if (bus.e_dstM_o !== 4'h2) begin errors++; $display("FAIL dstM_pass: got %h expected 2", bus.e_dstM_o); end
        bus.M_dstM_i = 4'h4;
        #1;
        checks++; if (bus.e_valA_o !== 64'h55) begin errors++; $display("FAIL fwd_nomatch: got %h expected 55", bus.e_valA_o); end
        bus.E_icode_i = I_PUSHQ;
        bus.M_dstM_i  = 4'h3;
        #1;
        checks++; if (bus.e_valA_o !== 64'hAB || bus.e_valE_o !== 64'hFF8) begin errors++; $display("FAIL fwd_pushq: got valA=%h valE=%h expected ab ff8", bus.e_valA_o, bus.e_valE_o); end
        bus.E_icode_i = I_MRMOVQ;
        #1;
        checks++; if (bus.e_valA_o !== 64'h55) begin errors++; $display("FAIL fwd_mrmovq: got %h expected 55", bus.e_valA_o); end
        drive(I_RRMOVQ, C_L, 64'h77, 64'd0, 64'd0);
        #1;
        checks++; if (bus.e_dstE_o !== RNONE) begin errors++; $display("FAIL cmovl_dstE: got %h expected f", bus.e_dstE_o); end
        checks++; if (bus.e_valE_o !== 64'h77) begin errors++; $display("FAIL cmov_valE: got %h expected 77", bus.e_valE_o); end
        bus.E_ifun_i = C_GE;
        #1;
        checks++; if (bus.e_dstE_o !== 4'h1) begin errors++; $display("FAIL cmovge_dstE: got %h expected 1", bus.e_dstE_o); end
        step();
    endtask

    task automatic test_back_to_back();
        int nb; logic [63:0] r; logic c;
        run_mul(64'd3, 64'd4, SAOK, nb, r, c);
        checks++; if (r !== 64'd12 || nb !== 17) begin errors++; $display("FAIL b2b_first: got %h busy=%0d expected c busy=17", r, nb); end
        run_mul(64'd5, 64'd5, SAOK, nb, r, c);
        checks++; if (r !== 64'd25 || nb !== 17) begin errors++; $display("FAIL b2b_second: got %h busy=%0d expected 19 busy=17", r, nb); end
    endtask

    task automatic test_exception();
        int nb; logic [63:0] r; logic c;
        run_mul(64'd0, 64'd5, SADR, nb, r, c);
        checks++; if (r !== 64'd0 || nb !== 17) begin errors++; $display("FAIL exc_mul: got %h busy=%0d expected 0 busy=17", r, nb); end
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_Cnd_o !== 1'b0) begin errors++; $display("FAIL exc_mul_cc: got %b expected 0", bus.e_Cnd_o); end
        step();
        drive(I_OPQ, ALUSUB, 64'd5, 64'd5, 64'd0);
        bus.W_stat_i = SHLT;
        step();
        drive(I_JXX, C_E, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        checks++; if (bus.e_Cnd_o !== 1'b0) begin errors++; $display("FAIL exc_sub_cc: got %b expected 0", bus.e_Cnd_o); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_mul_basic();
        test_mul_signed_zero();
        test_flush();
        test_reset_mid();
        test_forward_cmov();
        test_back_to_back();
        test_exception();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
